// File: rtl/run_stop_ctrl_if.sv
// -----------------------------------------------------------------------------
// run_stop_ctrl_if
//   Groups the pushbutton inputs and the control outputs of run_stop_ctrl.
//   Clock and reset stay plain ports on the module that uses this bundle.
//
//   Signals
//     btn_run   raw async pushbutton, active-high (toggles run/halt)
//     btn_step  raw async pushbutton, active-high (single step while halted)
//     stop      1 = downstream counter holds, 0 = counter advances
//     running   1 while the controller is in RUN
//     mode      controller state: 0 HALT, 1 RUN, 2 STEP
//
//   Modports
//     master  drives the buttons and observes the outputs (board / bench side)
//     slave   the controller itself
// -----------------------------------------------------------------------------
interface run_stop_ctrl_if;
  logic       btn_run;
  logic       btn_step;
  logic       stop;
  logic       running;
  logic [1:0] mode;

  modport master (
    output btn_run,
    output btn_step,
    input  stop,
    input  running,
    input  mode
  );

  modport slave (
    input  btn_run,
    input  btn_step,
    output stop,
    output running,
    output mode
  );
endinterface

// File: rtl/run_stop_ctrl.sv
// -----------------------------------------------------------------------------
// run_stop_ctrl
//   Upstream control stage for the 8-state counter/decoder. Two raw
//   pushbuttons are each synchronised (two flops) and debounced, and their
//   debounced rising edges drive a HALT/RUN/STEP state machine whose state
//   produces the counter's stop input.
//
//   Parameters
//     DEBOUNCE_CYCLES  consecutive differing cycles needed to accept a new
//                      button level (>= 2)
//     CNT_W            debounce counter width, 2**CNT_W-1 >= DEBOUNCE_CYCLES
//
//   Ports
//     clock    single clock, rising edge
//     reset_n  asynchronous active-low reset
//     bus      run_stop_ctrl_if.slave: btn_run, btn_step in; stop, running,
//              mode out
//
//   With the default DEBOUNCE_CYCLES=16 and a button first sampled high on
//   edge 1, the debounced level rises on edge 18 and stop changes on edge 19.
// -----------------------------------------------------------------------------
module run_stop_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic           clock,
  input  logic           reset_n,
  run_stop_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Index 0 = run button, index 1 = step button.
  logic [1:0] btn_raw;
  logic [1:0] press;

  assign btn_raw = {bus.btn_step, bus.btn_run};

  // ---------------------------------------------------------------------------
  // Per-button synchroniser, debouncer and press detector
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic             s1_reg;
      logic             s2_reg;
      logic             stable_reg;
      logic             stable_q_reg;
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          s1_reg       <= 1'b0;
          s2_reg       <= 1'b0;
          stable_reg   <= 1'b0;
          stable_q_reg <= 1'b0;
          cnt_reg      <= '0;
        end else begin
          s1_reg       <= btn_raw[gi];
          s2_reg       <= s1_reg;
          stable_q_reg <= stable_reg;
          // The counter runs only while the synchronised level disagrees
          // with the accepted level; any agreement restarts the run, so a
          // glitch shorter than DEBOUNCE_CYCLES leaves no trace.
          if (s2_reg != stable_reg) begin
            if (cnt_reg == CNT_LAST) begin
              stable_reg <= s2_reg;
              cnt_reg    <= '0;
            end else begin
              cnt_reg <= cnt_reg + CNT_ONE;
            end
          end else begin
            cnt_reg <= '0;
          end
        end
      end

      // One-cycle pulse on the debounced rising edge only.
      assign press[gi] = stable_reg & ~stable_q_reg;
    end
  endgenerate

  logic run_press;
  logic step_press;

  assign run_press  = press[0];
  assign step_press = press[1];

  // ---------------------------------------------------------------------------
  // HALT / RUN / STEP state machine
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_BAD  = 2'd3
  } state_t;

  state_t     state_reg;
  state_t     state_next;
  logic       stop_reg;
  logic       running_reg;
  logic [1:0] mode_reg;

  always_comb begin
    state_next = ST_HALT;
    case (state_reg)
      ST_HALT: begin
        // Run has priority when both buttons register on the same cycle.
        if (run_press)       state_next = ST_RUN;
        else if (step_press) state_next = ST_STEP;
        else                 state_next = ST_HALT;
      end
      ST_RUN: begin
        state_next = run_press ? ST_HALT : ST_RUN;
      end
      ST_STEP: begin
        // STEP always leaves after one cycle, giving exactly one advance.
        state_next = run_press ? ST_RUN : ST_HALT;
      end
      ST_BAD: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_HALT;
      end
    endcase
  end

  // Outputs are registered from the next state so they move on the same edge
  // as the state register and never glitch. state_next is never ST_BAD, so
  // an upset state still presents HALT outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= ST_HALT;
      stop_reg    <= 1'b1;
      running_reg <= 1'b0;
      mode_reg    <= 2'd0;
    end else begin
      state_reg   <= state_next;
      stop_reg    <= (state_next != ST_RUN) && (state_next != ST_STEP);
      running_reg <= (state_next == ST_RUN);
      mode_reg    <= (state_next == ST_BAD) ? 2'd0 : state_next;
    end
  end

  assign bus.stop    = stop_reg;
  assign bus.running = running_reg;
  assign bus.mode    = mode_reg;

endmodule

// File: tb/tb_run_stop_ctrl.sv
// -----------------------------------------------------------------------------
// tb_run_stop_ctrl
//   Directed bench for run_stop_ctrl (DEBOUNCE_CYCLES=16). Stimulus pushes the
//   expected output change (edge number and {stop,running,mode}) into a queue;
//   a monitor watching the outputs on the falling edge pops and compares each
//   time they change, and flags any change nobody asked for or any expected
//   change that never arrives. A small 3-bit counter model stands in for the
//   downstream decoder to confirm a STEP advances it exactly once.
// -----------------------------------------------------------------------------
module tb_run_stop_ctrl;

  typedef struct {
    int         cyc;
    logic       stop;
    logic       running;
    logic [1:0] mode;
  } exp_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  run_stop_ctrl_if bus ();

  run_stop_ctrl #(
    .DEBOUNCE_CYCLES (16),
    .CNT_W           (5)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  // Edge counter: after posedge N, cyc == N.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Downstream counter model: advances on every edge where stop was 0.
  logic [2:0] pstate = 3'd0;
  always @(posedge clock) if (bus.stop == 1'b0) pstate <= pstate + 3'd1;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, cyc);
    end else begin
      $display("ok   %s: %0d (edge %0d)", name, act, cyc);
    end
  endtask

  task automatic expect_at(input int c, input logic s, input logic r, input logic [1:0] m);
    exp_t e;
    e.cyc = c; e.stop = s; e.running = r; e.mode = m;
    exp_q.push_back(e);
  endtask

  function automatic int obs();
    return int'({bus.stop, bus.running, bus.mode});
  endfunction

  // Monitor
  initial begin
    logic [3:0] last_obs;
    logic [3:0] cur;
    exp_t       e;
    last_obs = 4'b1000;
    forever begin
      @(negedge clock);
      cur = {bus.stop, bus.running, bus.mode};
      if (!reset_n) begin
        last_obs = cur;
      end else if (cur !== last_obs) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_change: got %b at edge %0d, expected no change", cur, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("change_edge", cyc, e.cyc);
          chk("change_value", int'(cur), int'({e.stop, e.running, e.mode}));
        end
        last_obs = cur;
      end else if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
        e = exp_q.pop_front();
        n_vec++;
        n_bad++;
        $display("FAIL missing_change: outputs still %b at edge %0d, expected %b at edge %0d",
                 cur, cyc, {e.stop, e.running, e.mode}, e.cyc);
      end
    end
  end

  initial begin
    int         t0;
    logic [2:0] p0;

    bus.btn_run  = 1'b0;
    bus.btn_step = 1'b0;

    // 1: reset held while the buttons toggle
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      bus.btn_run  = i[0];
      bus.btn_step = i[1];
      #1 chk("reset_outputs", obs(), 4'b1000);
    end
    @(negedge clock);
    bus.btn_run  = 1'b0;
    bus.btn_step = 1'b0;
    @(posedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("after_release", obs(), 4'b1000);

    // 3: 10-cycle glitch on btn_run must be ignored
    bus.btn_run = 1'b1;
    repeat (10) @(negedge clock);
    bus.btn_run = 1'b0;
    repeat (30) @(negedge clock);
    chk("glitch_halt", obs(), 4'b1000);

    // 2: hold btn_run; RUN on edge 19, then nothing while held
    t0 = cyc;
    bus.btn_run = 1'b1;
    expect_at(t0 + 19, 1'b0, 1'b1, 2'd1);
    repeat (100) @(negedge clock);
    chk("run_held", obs(), 4'b0101);

    // 4: release, press again -> HALT on edge 19 of the new press
    bus.btn_run = 1'b0;
    repeat (20) @(negedge clock);
    t0 = cyc;
    bus.btn_run = 1'b1;
    expect_at(t0 + 19, 1'b1, 1'b0, 2'd0);
    repeat (30) @(negedge clock);
    bus.btn_run = 1'b0;
    repeat (20) @(negedge clock);

    // 5: single step from HALT, one cycle of stop=0
    p0 = pstate;
    t0 = cyc;
    bus.btn_step = 1'b1;
    expect_at(t0 + 19, 1'b0, 1'b0, 2'd2);
    expect_at(t0 + 20, 1'b1, 1'b0, 2'd0);
    repeat (40) @(negedge clock);
    bus.btn_step = 1'b0;
    chk("step_advance", int'(3'(pstate - p0)), 1);
    repeat (20) @(negedge clock);

    // 5b: step ignored while running
    t0 = cyc;
    bus.btn_run = 1'b1;
    expect_at(t0 + 19, 1'b0, 1'b1, 2'd1);
    repeat (30) @(negedge clock);
    bus.btn_run = 1'b0;
    repeat (20) @(negedge clock);
    bus.btn_step = 1'b1;
    repeat (40) @(negedge clock);
    bus.btn_step = 1'b0;
    repeat (20) @(negedge clock);
    chk("step_in_run", obs(), 4'b0101);
    t0 = cyc;
    bus.btn_run = 1'b1;
    expect_at(t0 + 19, 1'b1, 1'b0, 2'd0);
    repeat (30) @(negedge clock);
    bus.btn_run = 1'b0;
    repeat (20) @(negedge clock);

    // 6: both buttons together from HALT -> RUN
    t0 = cyc;
    bus.btn_run  = 1'b1;
    bus.btn_step = 1'b1;
    expect_at(t0 + 19, 1'b0, 1'b1, 2'd1);
    repeat (30) @(negedge clock);

    // 6b: asynchronous reset mid-RUN, checked before the next edge
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 chk("async_reset", obs(), 4'b1000);
    repeat (3) @(negedge clock);
    bus.btn_step = 1'b0;
    chk("reset_held", obs(), 4'b1000);

    // 6c: run still held through release counts as a fresh press
    @(posedge clock);
    #2 reset_n = 1'b1;
    t0 = cyc;
    expect_at(t0 + 19, 1'b0, 1'b1, 2'd1);
    repeat (30) @(negedge clock);
    chk("rerun_after_reset", obs(), 4'b0101);

    repeat (5) @(negedge clock);
    if (exp_q.size() != 0) chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
